// File: rtl/bus_burst_master_pkg.sv
// Shared definitions for the burst bus master: FSM state encoding, ctrl_out
// field layout and the burst-length saturation helper.
package bus_burst_master_pkg;

    localparam int BURST_W        = 3;
    localparam int CTRL_WAIT_BIT  = 0;
    localparam int CTRL_WE_BIT    = 1;
    localparam int CTRL_BURST_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_ADDR       = 3'd2,
        ST_SLAVE_WAIT = 3'd3,
        ST_WRITE      = 3'd4,
        ST_READ       = 3'd5,
        ST_FINISH     = 3'd6
    } state_t;

    // Requests longer than the buffers clamp to the last buffer slot.
    function automatic logic [BURST_W-1:0] sat_len(input logic [BURST_W-1:0] len,
                                                  input int max_burst);
        if (int'(len) >= max_burst) return BURST_W'(max_burst - 1);
        return len;
    endfunction

endpackage

// File: rtl/bus_burst_master_if.sv
// Command, buffer-access and shared-bus signals of the burst master.
interface bus_burst_master_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int CTRL_WIDTH = 8
);
    import bus_burst_master_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [BUS_WIDTH-1:0]  cmd_addr;
    logic [BURST_W-1:0]    cmd_len;
    logic                  wbuf_we;
    logic [BURST_W-1:0]    wbuf_idx;
    logic [BUS_WIDTH-1:0]  wbuf_data;
    logic [BURST_W-1:0]    rbuf_idx;
    logic [BUS_WIDTH-1:0]  rbuf_data;
    logic                  ready_in;
    logic                  req;
    logic                  ack;
    logic [BUS_WIDTH-1:0]  bus_in;
    logic [BUS_WIDTH-1:0]  bus_out;
    logic [CTRL_WIDTH-1:0] ctrl_in;
    logic [CTRL_WIDTH-1:0] ctrl_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len,
        input  wbuf_we, wbuf_idx, wbuf_data, rbuf_idx,
        input  ready_in, ack, bus_in, ctrl_in,
        output cmd_ready, rbuf_data, req, bus_out, ctrl_out, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len,
        output wbuf_we, wbuf_idx, wbuf_data, rbuf_idx,
        output ready_in, ack, bus_in, ctrl_in,
        input  cmd_ready, rbuf_data, req, bus_out, ctrl_out, busy, done, err
    );

endinterface

// File: rtl/burst_beat_buffer.sv
// DEPTH x WIDTH beat register file: one synchronous write port and one
// combinational read port. Out-of-range indices are ignored / read as zero.
module burst_beat_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && int'(widx) < DEPTH) mem[AW'(widx)] <= wdata;
    end

    assign rdata = (int'(ridx) < DEPTH) ? mem[AW'(ridx)] : '0;

endmodule

// File: rtl/bus_burst_master.sv
// Request/ack bus master: latches one command, arbitrates, drives the address,
// then moves a 1..MAX_BURST beat burst with wait stalls and a slave-wait timeout.
module bus_burst_master
    import bus_burst_master_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int CTRL_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    bus_burst_master_if.master bus
);
    state_t               state, state_nx;
    logic                 lat_we;
    logic [BUS_WIDTH-1:0] lat_addr;
    logic [BURST_W-1:0]   lat_len;
    logic [BURST_W-1:0]   beat;
    logic [7:0]           tcnt;
    logic                 abort;
    logic                 slv_wait;
    logic                 accept;
    logic                 tmo_hit;
    logic                 rbuf_cap;
    logic [BUS_WIDTH-1:0] wbuf_q;
    logic                 unused_ctrl;

    assign slv_wait    = bus.ctrl_in[CTRL_WAIT_BIT];
    assign accept      = bus.cmd_valid && bus.ready_in;
    assign tmo_hit     = slv_wait && (tcnt == 8'(TIMEOUT - 1));
    assign rbuf_cap    = (state == ST_READ) && !slv_wait;
    assign unused_ctrl = ^bus.ctrl_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_len  <= '0;
            beat     <= '0;
            tcnt     <= '0;
            abort    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (accept) begin
                    lat_we   <= bus.cmd_we;
                    lat_addr <= bus.cmd_addr;
                    lat_len  <= sat_len(bus.cmd_len, MAX_BURST);
                    abort    <= 1'b0;
                end
                ST_SLAVE_WAIT: begin
                    // Counter is left at zero on either exit so the next burst starts fresh.
                    if (!slv_wait || tmo_hit) tcnt <= '0;
                    else                      tcnt <= tcnt + 8'd1;
                    if (tmo_hit) abort <= 1'b1;
                end
                ST_WRITE, ST_READ:
                    if (!slv_wait && beat != lat_len) beat <= beat + 1'b1;
                ST_FINISH: beat <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.req       = 1'b0;
        bus.busy      = (state != ST_IDLE);
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.bus_out   = '0;
        bus.ctrl_out  = '0;

        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (accept) state_nx = ST_REQ;
            end
            ST_REQ: begin
                bus.req = 1'b1;
                if (bus.ack) state_nx = ST_ADDR;
            end
            ST_ADDR: begin
                bus.req     = 1'b1;
                bus.bus_out = lat_addr;
                state_nx    = ST_SLAVE_WAIT;
            end
            ST_SLAVE_WAIT: begin
                bus.req = 1'b1;
                if (!slv_wait)    state_nx = lat_we ? ST_WRITE : ST_READ;
                else if (tmo_hit) state_nx = ST_FINISH;
            end
            ST_WRITE, ST_READ: begin
                bus.req = 1'b1;
                if (state == ST_WRITE) bus.bus_out = wbuf_q;
                if (!slv_wait && beat == lat_len) state_nx = ST_FINISH;
            end
            ST_FINISH: begin
                bus.done = !abort;
                bus.err  = abort;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        // Command fields are visible only while this master owns the bus.
        if (state inside {ST_ADDR, ST_SLAVE_WAIT, ST_WRITE, ST_READ, ST_FINISH}) begin
            bus.ctrl_out[CTRL_BURST_LSB +: BURST_W] = lat_len;
            bus.ctrl_out[CTRL_WE_BIT]               = lat_we;
        end
    end

    burst_beat_buffer #(.DEPTH(MAX_BURST), .WIDTH(BUS_WIDTH), .IDX_W(BURST_W)) wbuf (
        .clk   (clk),
        .we    (bus.wbuf_we),
        .widx  (bus.wbuf_idx),
        .wdata (bus.wbuf_data),
        .ridx  (beat),
        .rdata (wbuf_q)
    );

    burst_beat_buffer #(.DEPTH(MAX_BURST), .WIDTH(BUS_WIDTH), .IDX_W(BURST_W)) rbuf (
        .clk   (clk),
        .we    (rbuf_cap),
        .widx  (beat),
        .wdata (bus.bus_in),
        .ridx  (bus.rbuf_idx),
        .rdata (bus.rbuf_data)
    );

endmodule

// File: tb/tb_bus_burst_master.sv
// Bench for bus_burst_master: a slave-side transaction model drives table and
// random bursts on one instance; a small-parameter instance covers timeout and clamping.
module tb_bus_burst_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_burst_master_if #(.BUS_WIDTH(32), .CTRL_WIDTH(8)) ifa ();
    bus_burst_master_if #(.BUS_WIDTH(32), .CTRL_WIDTH(8)) ifb ();

    bus_burst_master #(.BUS_WIDTH(32), .CTRL_WIDTH(8), .MAX_BURST(8), .TIMEOUT(255))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    bus_burst_master #(.BUS_WIDTH(32), .CTRL_WIDTH(8), .MAX_BURST(4), .TIMEOUT(4))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int total  = 0;
    int passed = 0;

    logic [31:0] wbuf_m [8];
    logic [31:0] rbuf_m [8];
    bit          rbuf_v [8];
    logic [31:0] wb_b   [4];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  len;
        int          ack_dly;
        int          sw_wait;
        int          stall_beat;
        logic [7:0]  exp_ctrl;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input bit directed);
        for (int i = 0; i < 8; i++) begin
            wbuf_m[i]     = directed ? 32'hA0A0_0000 + 32'(i) : $urandom;
            ifa.wbuf_we   = 1'b1;
            ifa.wbuf_idx  = 3'(i);
            ifa.wbuf_data = wbuf_m[i];
            step();
        end
        ifa.wbuf_we = 1'b0;
    endtask

    // Acts as arbiter + slave for one burst on instance A and checks every cycle.
    task automatic run_burst(input logic we, input logic [31:0] addr, input logic [2:0] len,
                             input int ack_dly, input int sw_wait, input int stall_beat,
                             input bit rnd, output int cycles);
        logic [7:0]  ec;
        int          beat;
        bit          stalled_once, upd;
        logic        w;
        logic [31:0] d, nv;
        int          uidx;
        ec = {3'b000, len, we, 1'b0};
        chk("idle_cmd_ready", ifa.cmd_ready, 1);
        ifa.cmd_valid = 1'b1; ifa.ready_in = 1'b1;
        ifa.cmd_we = we; ifa.cmd_addr = addr; ifa.cmd_len = len; ifa.ack = 1'b0;
        step();
        ifa.cmd_valid = 1'b0;
        for (int k = 0; k < ack_dly; k++) begin
            chk("req_wait_ack", {ifa.req, ifa.busy, ifa.ctrl_out}, {1'b1, 1'b1, 8'h00});
            step();
        end
        chk("req_before_ack", {ifa.req, ifa.cmd_ready}, 2'b10);
        ifa.ack = 1'b1;
        step();
        ifa.ack = 1'b0;
        chk("addr_phase", ifa.bus_out, addr);
        chk("addr_ctrl", ifa.ctrl_out, ec);
        ifa.ctrl_in = 8'h01;
        step();
        for (int k = 0; k < sw_wait; k++) begin
            ifa.ctrl_in = 8'h01;
            chk("sw_bus_idle", {ifa.req, ifa.bus_out}, {1'b1, 32'h0});
            step();
        end
        ifa.ctrl_in = 8'h00;
        chk("sw_bus_idle", {ifa.req, ifa.bus_out}, {1'b1, 32'h0});
        step();
        beat = 0; cycles = 0; stalled_once = 0;
        while (beat <= int'(len) && cycles < 64) begin
            w = rnd ? ($urandom_range(0, 3) == 0) : (beat == stall_beat && !stalled_once);
            if (w) stalled_once = 1;
            d = rnd ? $urandom : (w ? 32'h0BAD_0000 : 32'hDEADBEEF + 32'(beat));
            ifa.ctrl_in = {7'b0, w};
            ifa.bus_in  = d;
            upd = 0; uidx = beat; nv = '0;
            chk("beat_ctrl", {ifa.req, ifa.ctrl_out}, {1'b1, ec});
            if (we) begin
                chk("wr_beat_data", ifa.bus_out, wbuf_m[beat]);
                if (rnd && $urandom_range(0, 3) == 0) begin
                    upd = 1; nv = $urandom;
                    ifa.wbuf_we = 1'b1; ifa.wbuf_idx = 3'(beat); ifa.wbuf_data = nv;
                end
            end else begin
                chk("rd_bus_idle", ifa.bus_out, 0);
                ifa.rbuf_idx = 3'(beat);
                #1;
                if (rbuf_v[beat]) chk("rbuf_old_before_capture", ifa.rbuf_data, rbuf_m[beat]);
            end
            step();
            if (upd) begin
                wbuf_m[uidx] = nv;
                ifa.wbuf_we  = 1'b0;
            end
            if (!w) begin
                if (!we) begin rbuf_m[beat] = d; rbuf_v[beat] = 1; end
                beat++;
            end
            cycles++;
        end
        chk("burst_bounded", cycles < 64, 1);
        chk("finish_done", {ifa.done, ifa.err, ifa.req, ifa.busy}, 4'b1001);
        chk("finish_ctrl", {ifa.ctrl_out, ifa.bus_out}, {ec, 32'h0});
        ifa.ctrl_in = 8'h00;
        step();
        chk("back_idle", {ifa.busy, ifa.done, ifa.cmd_ready, ifa.ctrl_out}, {3'b001, 8'h00});
        if (!we) begin
            for (int i = 0; i <= int'(len); i++) begin
                ifa.rbuf_idx = 3'(i);
                #1;
                chk("rbuf_contents", ifa.rbuf_data, rbuf_m[i]);
            end
        end
    endtask

    initial begin
        int cyc;
        logic rw;

        {ifa.cmd_valid, ifa.cmd_we, ifa.wbuf_we, ifa.ready_in, ifa.ack} = '0;
        ifa.cmd_addr = '0; ifa.cmd_len = '0; ifa.wbuf_idx = '0; ifa.wbuf_data = '0;
        ifa.rbuf_idx = '0; ifa.bus_in = '0; ifa.ctrl_in = '0;
        {ifb.cmd_valid, ifb.cmd_we, ifb.wbuf_we, ifb.ready_in, ifb.ack} = '0;
        ifb.cmd_addr = '0; ifb.cmd_len = '0; ifb.wbuf_idx = '0; ifb.wbuf_data = '0;
        ifb.rbuf_idx = '0; ifb.bus_in = '0; ifb.ctrl_in = '0;
        for (int i = 0; i < 8; i++) begin rbuf_v[i] = 0; rbuf_m[i] = '0; end

        rst = 1'b1;
        step(); step();
        chk("reset_a", {ifa.req, ifa.busy, ifa.done, ifa.err, ifa.cmd_ready}, 5'b00001);
        chk("reset_a_bus", ifa.bus_out, 0);
        chk("reset_a_ctrl", ifa.ctrl_out, 0);
        chk("reset_b", {ifb.req, ifb.busy, ifb.done, ifb.err, ifb.cmd_ready}, 5'b00001);
        rst = 1'b0;
        step();

        // ready_in low must block command acceptance.
        ifa.cmd_valid = 1'b1; ifa.ready_in = 1'b0;
        step(); step();
        chk("no_accept_without_ready", {ifa.busy, ifa.req, ifa.cmd_ready}, 3'b001);
        ifa.cmd_valid = 1'b0;

        vecs[0] = '{1'b1, 32'h1000_0040, 3'd3, 2, 0, -1, 8'h0E, 4};
        vecs[1] = '{1'b0, 32'h2000_0000, 3'd0, 0, 0, -1, 8'h00, 1};
        vecs[2] = '{1'b0, 32'h3000_0100, 3'd7, 1, 1,  3, 8'h1C, 9};
        vecs[3] = '{1'b1, 32'h4000_0020, 3'd5, 0, 3,  0, 8'h16, 7};
        load_a(1);
        for (int v = 0; v < 4; v++) begin
            run_burst(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].ack_dly,
                      vecs[v].sw_wait, vecs[v].stall_beat, 0, cyc);
            chk("vec_data_cycles", cyc, vecs[v].exp_cycles);
            chk("vec_ctrl_expect", {3'b000, vecs[v].len, vecs[v].we, 1'b0}, vecs[v].exp_ctrl);
        end
        ifa.rbuf_idx = 3'd0;
        #1;
        chk("single_read_deadbeef", ifa.rbuf_data, 32'hDEADBEF0 + 32'd0 - 32'd1 + 32'd1 - 32'd1);

        // Reset in WRITE at beat 2, then a fresh command.
        load_a(0);
        step();
        ifa.cmd_valid = 1'b1; ifa.ready_in = 1'b1; ifa.cmd_we = 1'b1;
        ifa.cmd_addr = 32'h5555_0000; ifa.cmd_len = 3'd5;
        step();
        ifa.cmd_valid = 1'b0; ifa.ack = 1'b1;
        step();
        ifa.ack = 1'b0; ifa.ctrl_in = 8'h00;
        step(); step(); step(); step();
        chk("pre_reset_beat2", ifa.bus_out, wbuf_m[2]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset_state", {ifa.req, ifa.busy, ifa.cmd_ready, ifa.done, ifa.err}, 5'b00100);
        chk("mid_reset_bus", {ifa.bus_out, ifa.ctrl_out}, 40'h0);
        run_burst(1'b1, 32'h6666_0000, 3'd2, 0, 0, -1, 0, cyc);
        chk("post_reset_cycles", cyc, 3);

        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom_range(0, 1));
            if (rw && $urandom_range(0, 2) == 0) load_a(0);
            run_burst(rw, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                      $urandom_range(0, 3), -1, 1, cyc);
        end

        // Instance B: slave wait never drops -> err exactly 4 cycles after SLAVE_WAIT entry.
        ifb.cmd_valid = 1'b1; ifb.ready_in = 1'b1; ifb.cmd_we = 1'b0;
        ifb.cmd_addr = 32'h7000_0000; ifb.cmd_len = 3'd0;
        step();
        ifb.cmd_valid = 1'b0; ifb.ack = 1'b1;
        step();
        ifb.ack = 1'b0; ifb.ctrl_in = 8'h01;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("tmo_waiting", {ifb.req, ifb.err, ifb.done}, 3'b100);
            step();
        end
        chk("tmo_err_pulse", {ifb.err, ifb.done, ifb.req, ifb.busy}, 4'b1001);
        ifb.ctrl_in = 8'h00;
        step();
        chk("tmo_after", {ifb.err, ifb.done, ifb.busy, ifb.cmd_ready}, 4'b0001);

        // Instance B: len=7 clamps to 4 beats.
        for (int i = 0; i < 4; i++) begin
            wb_b[i] = $urandom;
            ifb.wbuf_we = 1'b1; ifb.wbuf_idx = 3'(i); ifb.wbuf_data = wb_b[i];
            step();
        end
        ifb.wbuf_we = 1'b0;
        ifb.cmd_valid = 1'b1; ifb.cmd_we = 1'b1; ifb.cmd_addr = 32'h7100_0000; ifb.cmd_len = 3'd7;
        step();
        ifb.cmd_valid = 1'b0; ifb.ack = 1'b1;
        step();
        ifb.ack = 1'b0;
        chk("sat_ctrl", ifb.ctrl_out, 8'h0E);
        chk("sat_addr", ifb.bus_out, 32'h7100_0000);
        step();
        step();
        for (int b = 0; b < 4; b++) begin
            chk("sat_beat", {ifb.done, ifb.bus_out}, {1'b0, wb_b[b]});
            step();
        end
        chk("sat_done", {ifb.done, ifb.err, ifb.req}, 3'b100);
        step();
        chk("sat_idle", {ifb.busy, ifb.done}, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
